// File: rtl/swt16_pkg.sv
// Shared encodings and default widths for the data-memory arbiter slice.
package swt16_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH = 12;
  localparam int unsigned DMEM_WORD_WIDTH = 16;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    AUX  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter; clear together with increment loads 1.
module sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != TOP)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: core priority, aux starvation guard, aux lock bursts.
// Define DMEM_ARB_STATS_EN to add saturating stall/grant statistics outputs.
module dmem_arbiter #(
  parameter int unsigned DMEM_ADDR_WIDTH = swt16_pkg::DMEM_ADDR_WIDTH,
  parameter int unsigned DMEM_WORD_WIDTH = swt16_pkg::DMEM_WORD_WIDTH,
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned LOCK_MAX        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       core_req,
  input  logic                       core_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] core_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] core_wdata,
  output logic                       core_gnt,
  output logic                       core_stall,
  output logic                       core_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] core_rdata,
  input  logic                       aux_req,
  input  logic                       aux_we,
  input  logic                       aux_lock,
  input  logic [DMEM_ADDR_WIDTH-1:0] aux_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] aux_wdata,
  output logic                       aux_gnt,
  output logic                       aux_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] aux_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] mem_wdata,
  input  logic [DMEM_WORD_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]                stat_core_stalls,
  output logic [15:0]                stat_aux_grants
`endif
);

  import swt16_pkg::*;

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned LOCK_W   = 8;
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);
  localparam logic [LOCK_W-1:0]   LOCK_TOP   = LOCK_W'(LOCK_MAX);

  arb_state_t state_q, state_d;
  rd_owner_t  rd_owner_q, rd_owner_d;
  logic       no_relock_q, no_relock_d;

  logic [STARVE_W-1:0] starve_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                starve_inc, starve_clr;
  logic                lock_inc, lock_clr;
  logic                lock_hold, lock_expired, aux_forced, relock_block;

  sat_counter #(
    .WIDTH(STARVE_W),
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .count(starve_cnt)
  );

  sat_counter #(
    .WIDTH(LOCK_W),
    .LIMIT(LOCK_MAX)
  ) u_lock_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (lock_inc),
    .clr  (lock_clr),
    .count(lock_cnt)
  );

  // A LOCK cycle that drops aux_lock or exhausts the budget arbitrates as ARB.
  always_comb begin
    lock_hold    = (state_q == LOCK) && aux_lock && (lock_cnt != LOCK_TOP);
    lock_expired = (state_q == LOCK) && aux_lock && (lock_cnt == LOCK_TOP);
    aux_forced   = aux_req && (starve_cnt == STARVE_TOP);
    relock_block = lock_expired || (no_relock_q && core_req);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB;
      rd_owner_q  <= NONE;
      no_relock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_owner_q  <= rd_owner_d;
      no_relock_q <= no_relock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!lock_hold) begin
      state_d = (aux_gnt && aux_lock && !relock_block) ? LOCK : ARB;
    end

    no_relock_d = no_relock_q;
    if (lock_expired) begin
      no_relock_d = 1'b1;
    end else if (core_gnt || !core_req) begin
      no_relock_d = 1'b0;
    end

    rd_owner_d = NONE;
    if (core_gnt && !core_we) begin
      rd_owner_d = CORE;
    end else if (aux_gnt && !aux_we) begin
      rd_owner_d = AUX;
    end

    starve_inc = core_gnt && aux_req;
    starve_clr = aux_gnt || !aux_req;
    lock_clr   = !lock_hold && (state_d == LOCK);
    lock_inc   = (state_q == LOCK) || lock_clr;
  end

  // Grants are qualified by reset so nothing reaches DMEM while it is held low.
  always_comb begin
    core_gnt = 1'b0;
    aux_gnt  = 1'b0;
    if (reset) begin
      if (lock_hold) begin
        aux_gnt = aux_req;
      end else if (core_req && !aux_forced) begin
        core_gnt = 1'b1;
      end else begin
        aux_gnt = aux_req;
      end
    end
    core_stall = reset && core_req && !core_gnt;

    mem_en    = core_gnt || aux_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (aux_gnt) begin
      mem_we    = aux_we;
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
    end

    core_rvalid = (rd_owner_q == CORE);
    aux_rvalid  = (rd_owner_q == AUX);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    aux_rdata   = aux_rvalid ? mem_rdata : '0;
  end

`ifdef DMEM_ARB_STATS_EN
  sat_counter #(
    .WIDTH(16),
    .LIMIT(16'hFFFF)
  ) u_stat_stalls (
    .clock(clock),
    .reset(reset),
    .inc  (core_stall),
    .clr  (1'b0),
    .count(stat_core_stalls)
  );

  sat_counter #(
    .WIDTH(16),
    .LIMIT(16'hFFFF)
  ) u_stat_aux (
    .clock(clock),
    .reset(reset),
    .inc  (aux_gnt),
    .clr  (1'b0),
    .count(stat_aux_grants)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 16;
  localparam int unsigned SLIM = 4;
  localparam int unsigned LMAX = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata, aux_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .DMEM_ADDR_WIDTH(AW),
    .DMEM_WORD_WIDTH(DW),
    .STARVE_LIMIT   (SLIM),
    .LOCK_MAX       (LMAX)
  ) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 16) return 16'hBEEF;
    if (a == 32) return 16'hC020;
    if (a == 48) return 16'hA030;
    return DW'((a * 257) ^ 23130);
  endfunction

  // DMEM behaviour seen by the DUT: synchronous read, one cycle latency
  bit [DW-1:0] dmem [0:(1<<AW)-1];
  bit          dwr  [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        dmem[mem_addr] <= mem_wdata;
        dwr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= dwr[mem_addr] ? dmem[mem_addr] : init_word(int'(mem_addr));
      end
    end
  end

  // Reference model
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_starve, m_lockcyc, m_owner;
  bit            m_locked, m_norelock;
  logic [DW-1:0] m_rdata;
  bit            e_core, e_aux;

  int errors = 0;
  int checks = 0;
  int k;
  bit last_aux_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_starve = 0; m_lockcyc = 0; m_owner = 0;
    m_locked = 0; m_norelock = 0; m_rdata = '0;
  endtask

  function automatic void m_predict();
    bit excl;
    excl   = m_locked && aux_lock && (m_lockcyc < int'(LMAX));
    e_core = 0;
    e_aux  = 0;
    if (!reset) return;
    if (excl) e_aux = aux_req;
    else if (core_req && !(aux_req && m_starve >= int'(SLIM))) e_core = 1;
    else e_aux = aux_req;
  endfunction

  task automatic m_update();
    bit excl, expired;
    excl    = m_locked && aux_lock && (m_lockcyc < int'(LMAX));
    expired = m_locked && aux_lock && (m_lockcyc >= int'(LMAX));
    if (e_core && aux_req) m_starve = (m_starve < int'(SLIM)) ? m_starve + 1 : int'(SLIM);
    else if (e_aux || !aux_req) m_starve = 0;
    if (excl) m_lockcyc++;
    else begin
      m_locked  = e_aux && aux_lock && !expired && !(m_norelock && core_req);
      m_lockcyc = 1;
    end
    if (expired) m_norelock = 1;
    else if (e_core || !core_req) m_norelock = 0;
    m_owner = 0;
    if (e_core && !core_we) begin m_owner = 1; m_rdata = ref_mem[core_addr]; end
    else if (e_aux && !aux_we) begin m_owner = 2; m_rdata = ref_mem[aux_addr]; end
    if (e_core && core_we) ref_mem[core_addr] = core_wdata;
    if (e_aux && aux_we) ref_mem[aux_addr] = aux_wdata;
  endtask

  task automatic check_cycle();
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ewe = e_core ? core_we : (e_aux ? aux_we : 1'b0);
    ea  = e_core ? core_addr : (e_aux ? aux_addr : '0);
    ed  = e_core ? core_wdata : (e_aux ? aux_wdata : '0);
    check("core_gnt", core_gnt, e_core);
    check("aux_gnt", aux_gnt, e_aux);
    check("core_stall", core_stall, reset && core_req && !e_core);
    check("mem_en", mem_en, e_core || e_aux);
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("core_rvalid", core_rvalid, m_owner == 1);
    check("core_rdata", core_rdata, (m_owner == 1) ? m_rdata : '0);
    check("aux_rvalid", aux_rvalid, m_owner == 2);
    check("aux_rdata", aux_rdata, (m_owner == 2) ? m_rdata : '0);
  endtask

  task automatic step();
    #2;
    m_predict();
    check_cycle();
    @(posedge clock);
    if (reset) m_update(); else m_reset();
    #1;
  endtask

  task automatic idle();
    core_req = 0; aux_req = 0; aux_lock = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    m_reset();
    core_req = 1; core_we = 0; core_addr = '0; core_wdata = '0;
    aux_req = 1; aux_we = 0; aux_lock = 1; aux_addr = '0; aux_wdata = '0;

    // Reset held: outputs quiet even with both masters requesting
    #3;
    m_predict();
    check_cycle();
    @(negedge clock);
    idle();
    reset = 1;
    @(posedge clock); #1;

    // Core-only read of 0x010
    core_req = 1; core_we = 0; core_addr = 12'h010;
    #1; check("t1_gnt", core_gnt, 1); check("t1_stall", core_stall, 0);
    step();
    core_req = 0;
    #1; check("t1_rvalid", core_rvalid, 1); check("t1_rdata", core_rdata, 16'hBEEF);
    step();

    // Continuous contention: core x4, aux x1
    core_req = 1; core_we = 0; core_addr = 12'h040;
    aux_req = 1; aux_we = 0; aux_lock = 0; aux_addr = 12'h041;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("t2_core_gnt", core_gnt, (i % 5) != 4);
      check("t2_stall", core_stall, (i % 5) == 4);
      step();
    end
    idle(); step();

    // Locked burst of five aux writes against a busy core
    core_req = 1; core_we = 0; core_addr = 12'h050; aux_we = 1;
    for (int i = 0; i < 10; i++) begin
      k = (i < 4) ? 0 : i - 4;
      aux_addr = AW'(12'h100 + k); aux_wdata = DW'(16'h1111 + k);
      aux_req = (k < 5); aux_lock = (k < 5);
      #1;
      check("t3_aux_gnt", aux_gnt, (i >= 4) && (i < 9));
      check("t3_core_gnt", core_gnt, (i < 4) || (i == 9));
      check("t3_stall", core_stall, (i >= 4) && (i < 9));
      step();
    end
    idle(); step();
    for (int i = 0; i < 5; i++) check("t3_mem", dmem[12'h100 + i], 16'h1111 + i);

    // Lock held past its budget: forced release, core served, relock after starvation
    core_req = 1; core_we = 0; core_addr = 12'h060;
    aux_req = 1; aux_we = 1; aux_lock = 1; aux_addr = 12'h200;
    for (int i = 0; i < 26; i++) begin
      aux_wdata = DW'(16'h2000 + i);
      #1;
      check("t4_aux_gnt", aux_gnt, ((i >= 4) && (i <= 19)) || (i >= 24));
      check("t4_core_gnt", core_gnt, !(((i >= 4) && (i <= 19)) || (i >= 24)));
      step();
    end
    idle(); step();

    // Alternating reads: data returns to the issuing master only
    core_we = 0; aux_we = 0; aux_lock = 0; core_addr = 12'h020; aux_addr = 12'h030;
    for (int i = 0; i < 7; i++) begin
      core_req = (i < 6) && (i % 2 == 0);
      aux_req  = (i < 6) && (i % 2 == 1);
      #1;
      if (i > 0) begin
        check("t5_core_rvalid", core_rvalid, (i - 1) % 2 == 0);
        check("t5_core_rdata", core_rdata, ((i - 1) % 2 == 0) ? 16'hC020 : 16'h0);
        check("t5_aux_rvalid", aux_rvalid, (i - 1) % 2 == 1);
        check("t5_aux_rdata", aux_rdata, ((i - 1) % 2 == 1) ? 16'hA030 : 16'h0);
      end
      step();
    end

    // Reset while locked with a read outstanding
    core_req = 0; aux_req = 1; aux_lock = 1; aux_we = 0; aux_addr = 12'h030;
    step();
    step();
    #1; check("t6_pre_rvalid", aux_rvalid, 1);
    reset = 0;
    #1;
    check("t6_rst_rvalid", aux_rvalid, 0);
    check("t6_rst_rdata", aux_rdata, 0);
    check("t6_rst_gnt", aux_gnt, 0);
    m_reset();
    core_req = 1;
    step();
    idle();
    @(negedge clock); reset = 1;
    @(posedge clock); #1;
    core_req = 1; core_we = 0; core_addr = 12'h010;
    aux_req = 1; aux_lock = 1; aux_we = 0; aux_addr = 12'h030;
    #1; check("t6_first_gnt", core_gnt, 1);
    step();
    last_aux_gnt = e_aux;

    // Random traffic; aux keeps a pending request stable until granted
    for (int n = 0; n < 3000; n++) begin
      core_req   = ($urandom_range(0, 99) < 70);
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = AW'($urandom_range(0, 63));
      core_wdata = DW'($urandom);
      if (!aux_req || last_aux_gnt) begin
        aux_req   = ($urandom_range(0, 99) < 60);
        aux_we    = 1'($urandom_range(0, 1));
        aux_addr  = AW'($urandom_range(0, 63));
        aux_wdata = DW'($urandom);
        aux_lock  = m_locked ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 25);
      end
      step();
      last_aux_gnt = e_aux;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the core pipeline and an auxiliary master, such as a program loader or debug port. The core's requests come from the load-half and store-half decoder actions.
- Core has fixed priority, with a starvation guard for aux.
- Aux may lock the memory for back-to-back bursts.
- Returns 1-cycle-latency read data to whichever master issued the read.
- Drives the core stall signal used to freeze the pipeline.

Parameters:
DMEM_ADDR_WIDTH, 12, DMEM address width
DMEM_WORD_WIDTH, 16, DMEM data width
STARVE_LIMIT, 4, consecutive core wins over a pending aux before aux is forced a slot (1..15)
LOCK_MAX, 16, maximum consecutive locked cycles before forced unlock (2..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
core_req  in  1  core access request
core_we  in  1  1=store, 0=load
core_addr  in  DMEM_ADDR_WIDTH  core address
core_wdata  in  DMEM_WORD_WIDTH  store data
core_gnt  out  1  core access issued this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid
core_rdata  out  DMEM_WORD_WIDTH  core read data
aux_req  in  1  aux access request
aux_we  in  1  1=write, 0=read
aux_lock  in  1  request or hold exclusive ownership
aux_addr  in  DMEM_ADDR_WIDTH  aux address
aux_wdata  in  DMEM_WORD_WIDTH  aux write data
aux_gnt  out  1  aux access issued this cycle
aux_rvalid  out  1  aux read data valid
aux_rdata  out  DMEM_WORD_WIDTH  aux read data
mem_en  out  1  DMEM enable
mem_we  out  1  DMEM write enable
mem_addr  out  DMEM_ADDR_WIDTH  DMEM address
mem_wdata  out  DMEM_WORD_WIDTH  DMEM write data
mem_rdata  in  DMEM_WORD_WIDTH  DMEM read data, valid 1 cycle after a read enable

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ARB, starve_cnt=0, lock_cnt=0, rd_owner=NONE.
  - core_rvalid=aux_rvalid=0; *_rdata=0.
  - gnt, stall and mem_* outputs forced 0 while reset is low.
- Grants are combinational in the request cycle. mem_* mirror the winner's we/addr/wdata. mem_en = core_gnt | aux_gnt. Grants are mutually exclusive.
- With no grant, mem_we=0 and mem_addr/mem_wdata=0.
- State ARB:
  - Core wins unless aux_req=1 and starve_cnt==STARVE_LIMIT; then aux wins.
  - Aux wins if core_req=0.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when core is granted while aux_req=1.
  - Clears when aux is granted or aux_req=0.
- ARB->LOCK: aux granted with aux_lock=1; lock_cnt loads 1.
- State LOCK:
  - aux_gnt=aux_req; core_gnt=0, so core_stall=core_req.
  - lock_cnt increments on every cycle in LOCK, whether or not aux_req.
  - LOCK->ARB when aux_lock=0. Arbitration in that cycle already follows ARB rules.
  - LOCK->ARB forced when lock_cnt==LOCK_MAX. Sets no_relock=1.
- no_relock=1:
  - Aux cannot enter LOCK from ARB.
  - Cleared by the next core grant, or immediately if core_req=0 for a cycle.
- Read return:
  - rd_owner is registered from the granted read (we=0).
  - Next cycle: the owner's rvalid=1 and its rdata=mem_rdata; the other master's rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads pipeline at 1 per cycle.
- Simultaneous request with starve_cnt<STARVE_LIMIT: core wins; aux waits with aux_gnt=0. Aux holds its request stable until granted.
- Reset mid-lock or mid-read: outstanding rvalid is dropped; no rdata is delivered after reset.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - Adds outputs stat_core_stalls and stat_aux_grants, 16 bits each.
  - Counters saturate at 16'hFFFF and clear on reset.
  - stat_core_stalls counts cycles with core_stall=1.
  - stat_aux_grants counts cycles with aux_gnt=1.
- Undefined: ports and counters are absent; arbitration is identical.

Decomposition:
- Shared package swt16_pkg holds:
  - state encodings ARB/LOCK
  - rd_owner encodings NONE/CORE/AUX
  - default widths DMEM_ADDR_WIDTH/DMEM_WORD_WIDTH
- One sub-module: sat_counter, parameterised width, limit, increment and clear. It is used for starve_cnt, lock_cnt and both stat counters.

Test Plan:
- Core-only read at 0x010 with DMEM holding 0xBEEF -> core_gnt=1 same cycle; core_rvalid=1 and core_rdata=0xBEEF next cycle; core_stall=0.
- Both masters request continuously with STARVE_LIMIT=4 -> grants follow core x4, aux x1, repeating; core_stall=1 exactly on the aux cycles.
- Aux locked burst writes 0x1111..0x1115 to 0x100..0x104 while core_req=1 -> 5 aux grants in sequence, core_stall=1 throughout; core granted in the cycle aux_lock drops.
- Aux holds lock with LOCK_MAX=16 and core_req=1 -> forced release after 16 cycles; core granted next; aux lock attempt rejected until that core grant.
- Alternating reads, core 0x020 then aux 0x030, back-to-back -> rvalid strobes alternate core/aux with the correct data each cycle; no cross-delivery.
- reset driven low while a read is outstanding and in LOCK -> rvalids 0 immediately; state=ARB; first core request after release is granted in the same cycle.
